// File: rtl/control_sequencer_if.sv
// Control bundle between the instruction sequencer and the datapath.
// master = sequencer side (drives strobes), slave = datapath/stimulus side.
interface control_sequencer_if #(
    parameter int ALUOP_W = 4
);
    logic               start;
    logic               stop;
    logic [31:0]        IR;

    logic               PCout, Zlowout, Zhighout, MDRout, Cout;
    logic               MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high;
    logic               IncPC, Read;
    logic               Gra, Grb, Grc, Rin, Rout;
    logic [ALUOP_W-1:0] operation;
    logic               run;
    logic               illegal;

    modport master (
        input  start, stop, IR,
        output PCout, Zlowout, Zhighout, MDRout, Cout,
        output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high,
        output IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        output operation, run, illegal
    );

    modport slave (
        output start, stop, IR,
        input  PCout, Zlowout, Zhighout, MDRout, Cout,
        input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high,
        input  IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        input  operation, run, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control-step sequencer: T0-T6 micro-steps, T1 stretched by MEM_WAIT.
// Strobes decode combinationally from the registered step; no backpressure beyond the fixed memory wait.
module control_sequencer #(
    parameter int OPCODE_W = 5,
    parameter int ALUOP_W  = 4,
    parameter int MEM_WAIT = 0
) (
    input logic                 Clock,
    input logic                 clear,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_IMM, C_MUL, C_NOP, C_HALT, C_ILL
    } cls_t;

    localparam logic [3:0] LP_WAIT_LAST = 4'(MEM_WAIT);

    state_t                r_state;
    logic [3:0]            r_wait;
    logic [OPCODE_W-1:0]   r_opc;
    logic [OPCODE_W-1:0]   w_opc;
    cls_t                  w_cls;
    cls_t                  w_xcls;
    logic                  w_unused_ir;

    function automatic cls_t f_cls(input logic [OPCODE_W-1:0] opc);
        cls_t c;
        if (opc >= OPCODE_W'(3) && opc <= OPCODE_W'(11))       c = C_ALU;
        else if (opc >= OPCODE_W'(12) && opc <= OPCODE_W'(14)) c = C_IMM;
        else if (opc >= OPCODE_W'(15) && opc <= OPCODE_W'(16)) c = C_MUL;
        else if (opc == OPCODE_W'(26))                         c = C_NOP;
        else if (opc == OPCODE_W'(27))                         c = C_HALT;
        else                                                   c = C_ILL;
        return c;
    endfunction

    assign w_opc       = bus.IR[31 -: OPCODE_W];
    assign w_unused_ir = ^bus.IR[31-OPCODE_W:0];
    // IR is only trusted from T3; the opcode is captured there for the later steps.
    assign w_cls       = f_cls(w_opc);
    assign w_xcls      = f_cls(r_opc);

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_opc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) r_state <= S_T0;
                S_T0: begin
                    r_state <= S_T1;
                    r_wait  <= '0;
                end
                S_T1: begin
                    if (r_wait == LP_WAIT_LAST) begin
                        r_state <= S_T2;
                        r_wait  <= '0;
                    end else begin
                        r_wait  <= r_wait + 4'd1;
                    end
                end
                S_T2: r_state <= S_T3;
                S_T3: begin
                    r_opc <= w_opc;
                    case (w_cls)
                        C_ALU, C_IMM, C_MUL: r_state <= S_T4;
                        C_HALT:              r_state <= S_HALT;
                        default:             r_state <= bus.stop ? S_IDLE : S_T0;
                    endcase
                end
                S_T4: r_state <= S_T5;
                S_T5: begin
                    if (w_xcls == C_MUL) r_state <= S_T6;
                    else                 r_state <= bus.stop ? S_IDLE : S_T0;
                end
                S_T6:   r_state <= bus.stop ? S_IDLE : S_T0;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.PCout     = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.Zhighout  = 1'b0;
        bus.MDRout    = 1'b0;
        bus.Cout      = 1'b0;
        bus.MARin     = 1'b0;
        bus.PCin      = 1'b0;
        bus.MDRin     = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.HIin      = 1'b0;
        bus.LOin      = 1'b0;
        bus.Zin_low   = 1'b0;
        bus.Zin_high  = 1'b0;
        bus.IncPC     = 1'b0;
        bus.Read      = 1'b0;
        bus.Gra       = 1'b0;
        bus.Grb       = 1'b0;
        bus.Grc       = 1'b0;
        bus.Rin       = 1'b0;
        bus.Rout      = 1'b0;
        bus.operation = '0;
        bus.illegal   = 1'b0;
        bus.run       = (r_state != S_IDLE) && (r_state != S_HALT);
        case (r_state)
            S_T0: begin
                bus.PCout   = 1'b1;
                bus.MARin   = 1'b1;
                bus.IncPC   = 1'b1;
                bus.Zin_low = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                bus.PCin    = (r_wait == LP_WAIT_LAST);
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                case (w_cls)
                    C_ALU, C_IMM, C_MUL: begin
                        bus.Grb  = 1'b1;
                        bus.Rout = 1'b1;
                        bus.Yin  = 1'b1;
                    end
                    C_ILL:   bus.illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                bus.operation = r_opc[ALUOP_W-1:0];
                bus.Zin_low   = 1'b1;
                case (w_xcls)
                    C_ALU: begin
                        bus.Grc  = 1'b1;
                        bus.Rout = 1'b1;
                    end
                    C_IMM: bus.Cout = 1'b1;
                    C_MUL: begin
                        bus.Grc      = 1'b1;
                        bus.Rout     = 1'b1;
                        bus.Zin_high = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (w_xcls == C_MUL) begin
                    bus.LOin = 1'b1;
                end else begin
                    bus.Gra = 1'b1;
                    bus.Rin = 1'b1;
                end
            end
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: two instances (MEM_WAIT 0 and 3) checked every cycle
// against an instruction-level expectation queue, plus literal checks pinning the model.
module tb_control_sequencer;

    localparam int P_PCOUT = 0,  P_ZLOUT = 1,  P_ZHOUT = 2,  P_MDROUT = 3, P_COUT = 4;
    localparam int P_MARIN = 5,  P_PCIN = 6,   P_MDRIN = 7,  P_IRIN = 8,   P_YIN = 9;
    localparam int P_HIIN = 10,  P_LOIN = 11,  P_ZINL = 12,  P_ZINH = 13,  P_INCPC = 14;
    localparam int P_READ = 15,  P_GRA = 16,   P_GRB = 17,   P_GRC = 18,   P_RIN = 19;
    localparam int P_ROUT = 20,  P_RUN = 21,   P_ILL = 22;
    localparam logic [31:0] BUS_MASK = 32'h0010_001F;
    localparam int C_ALU = 0, C_IMM = 1, C_MUL = 2, C_NOP = 3, C_HALT = 4, C_ILL = 5;

    logic        Clock = 1'b0;
    logic        clear = 1'b0;
    logic        start_s [2];
    logic        stop_s  [2];
    logic [31:0] ir_s    [2];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_n = 0;

    always #5 Clock = ~Clock;

    function automatic logic [31:0] bt(input int i);
        return 32'h1 << i;
    endfunction

    function automatic int cls_of(input logic [4:0] o);
        if (o >= 5'd3 && o <= 5'd11)  return C_ALU;
        if (o >= 5'd12 && o <= 5'd14) return C_IMM;
        if (o == 5'd15 || o == 5'd16) return C_MUL;
        if (o == 5'd26)               return C_NOP;
        if (o == 5'd27)               return C_HALT;
        return C_ILL;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_ch
        localparam int MW = (g == 0) ? 0 : 3;
        control_sequencer_if #(.ALUOP_W(4)) bus ();
        logic [31:0] act_v;
        logic [31:0] exp_v;
        logic [31:0] q [$];

        assign bus.start = start_s[g];
        assign bus.stop  = stop_s[g];
        assign bus.IR    = ir_s[g];
        assign act_v = {4'b0, bus.operation, 1'b0, bus.illegal, bus.run, bus.Rout, bus.Rin,
                        bus.Grc, bus.Grb, bus.Gra, bus.Read, bus.IncPC, bus.Zin_high,
                        bus.Zin_low, bus.LOin, bus.HIin, bus.Yin, bus.IRin, bus.MDRin,
                        bus.PCin, bus.MARin, bus.Cout, bus.MDRout, bus.Zhighout,
                        bus.Zlowout, bus.PCout};

        control_sequencer #(.OPCODE_W(5), .ALUOP_W(4), .MEM_WAIT(MW)) u_dut (
            .Clock (Clock),
            .clear (clear),
            .bus   (bus)
        );

        // Expectation model: an instruction expands into its list of steps; mode 0 idle, 1 running, 2 halted.
        initial begin : model
            int          mode;
            int          c;
            bit          hlt;
            bit          go;
            logic [4:0]  o;
            logic [31:0] r;
            mode  = 0;
            hlt   = 1'b0;
            exp_v = '0;
            forever begin
                @(posedge Clock or negedge clear);
                if (!clear) begin
                    q.delete();
                    mode  = 0;
                    hlt   = 1'b0;
                    exp_v = '0;
                end else if (q.size() > 0) begin
                    exp_v = q.pop_front();
                end else begin
                    go = 1'b0;
                    if (mode == 0) go = start_s[g];
                    else if (mode == 1) begin
                        if (hlt)            mode = 2;
                        else if (stop_s[g]) mode = 0;
                        else                go = 1'b1;
                    end
                    if (go) begin
                        o    = ir_s[g][31:27];
                        c    = cls_of(o);
                        hlt  = (c == C_HALT);
                        mode = 1;
                        r    = bt(P_RUN);
                        q.push_back(r | bt(P_PCOUT) | bt(P_MARIN) | bt(P_INCPC) | bt(P_ZINL));
                        for (int k = 0; k <= MW; k++)
                            q.push_back(r | bt(P_ZLOUT) | bt(P_READ) | bt(P_MDRIN) |
                                        ((k == MW) ? bt(P_PCIN) : 32'h0));
                        q.push_back(r | bt(P_MDROUT) | bt(P_IRIN));
                        if (c <= C_MUL) begin
                            q.push_back(r | bt(P_GRB) | bt(P_ROUT) | bt(P_YIN));
                            r = r | bt(P_ZINL) | (32'(o[3:0]) << 24);
                            if (c == C_ALU) q.push_back(r | bt(P_GRC) | bt(P_ROUT));
                            if (c == C_IMM) q.push_back(r | bt(P_COUT));
                            if (c == C_MUL) q.push_back(r | bt(P_GRC) | bt(P_ROUT) | bt(P_ZINH));
                            r = bt(P_RUN) | bt(P_ZLOUT);
                            if (c == C_MUL) begin
                                q.push_back(r | bt(P_LOIN));
                                q.push_back(bt(P_RUN) | bt(P_ZHOUT) | bt(P_HIIN));
                            end else begin
                                q.push_back(r | bt(P_GRA) | bt(P_RIN));
                            end
                        end else begin
                            q.push_back(r | ((c == C_ILL) ? bt(P_ILL) : 32'h0));
                        end
                        exp_v = q.pop_front();
                    end else begin
                        exp_v = '0;
                    end
                end
            end
        end
    end

    int         last_pc0, per0, last_pc1, per1, rd_run, rd_max, pcin_run, cnt_ill;
    logic [3:0] op_seen;
    bit         op_zl, op_zh, rin_seen, grc_seen, cout_seen, lo_seen, hi_seen;

    task automatic reset_trk();
        last_pc0 = -1; per0 = 0; last_pc1 = -1; per1 = 0;
        rd_run = 0; rd_max = 0; pcin_run = 0; cnt_ill = 0;
        op_seen = 4'h0; op_zl = 0; op_zh = 0; rin_seen = 0; grc_seen = 0;
        cout_seen = 0; lo_seen = 0; hi_seen = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_ch(input int ch, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL ch%0d cycle %0d outputs: got %h expected %h", ch, cyc_n, a, e);
        end
        n_vec++;
        if (!$onehot0(a & BUS_MASK)) begin
            n_err++;
            $display("FAIL ch%0d cycle %0d bus drives: got %h expected at most one bit", ch, cyc_n,
                     a & BUS_MASK);
        end
    endtask

    task automatic cyc();
        logic [31:0] a0;
        logic [31:0] a1;
        @(negedge Clock);
        a0 = g_ch[0].act_v;
        a1 = g_ch[1].act_v;
        cmp_ch(0, a0, g_ch[0].exp_v);
        cmp_ch(1, a1, g_ch[1].exp_v);
        cyc_n++;
        if (a0[P_PCOUT]) begin
            if (last_pc0 >= 0) per0 = cyc_n - last_pc0;
            last_pc0 = cyc_n;
        end
        if (a1[P_PCOUT]) begin
            if (last_pc1 >= 0) per1 = cyc_n - last_pc1;
            last_pc1 = cyc_n;
        end
        rd_run = a1[P_READ] ? rd_run + 1 : 0;
        if (rd_run > rd_max) rd_max = rd_run;
        if (a1[P_PCIN]) pcin_run = rd_run;
        if (a0[27:24] != 4'h0) begin
            op_seen = a0[27:24];
            op_zl   = a0[P_ZINL];
            op_zh   = a0[P_ZINL] & a0[P_ZINH];
        end
        cnt_ill   += int'(a0[P_ILL]);
        rin_seen  |= a0[P_RIN];
        grc_seen  |= a0[P_GRC];
        cout_seen |= a0[P_COUT];
        lo_seen   |= a0[P_LOIN];
        hi_seen   |= a0[P_HIIN];
        #1;
    endtask

    task automatic run_one(input string nm, input logic [31:0] ir);
        ir_s[0]    = ir;
        stop_s[0]  = 1'b1;
        start_s[0] = 1'b1;
        cyc();
        start_s[0] = 1'b0;
        for (int i = 0; i < 30 && g_ch[0].act_v[P_RUN]; i++) cyc();
        chk(nm, 32'(g_ch[0].act_v[P_RUN]), 32'h0);
    endtask

    initial begin
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        stop_s[0]  = 1'b0; stop_s[1]  = 1'b0;
        ir_s[0]    = 32'h18A1_8000;
        ir_s[1]    = 32'h18A1_8000;
        reset_trk();
        repeat (2) cyc();
        chk("reset_outs_mw0", g_ch[0].act_v, 32'h0);
        chk("reset_outs_mw3", g_ch[1].act_v, 32'h0);
        clear = 1'b1;
        repeat (3) cyc();
        chk("idle_without_start", 32'(g_ch[0].act_v[P_RUN]), 32'h0);

        // Back-to-back ADD on both instances
        start_s[0] = 1'b1; start_s[1] = 1'b1;
        repeat (30) cyc();
        chk("add_period_mw0", 32'(per0), 32'd6);
        chk("add_period_mw3", 32'(per1), 32'd9);
        chk("read_run_mw3", 32'(rd_max), 32'd4);
        chk("pcin_on_4th_read", 32'(pcin_run), 32'd4);
        chk("add_operation", 32'(op_seen), 32'h3);
        chk("add_t4_zinlow", 32'(op_zl), 32'h1);
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        stop_s[0]  = 1'b1; stop_s[1]  = 1'b1;
        for (int i = 0; i < 20 && (g_ch[0].act_v[P_RUN] || g_ch[1].act_v[P_RUN]); i++) cyc();
        chk("add_stop_idle", {30'b0, g_ch[1].act_v[P_RUN], g_ch[0].act_v[P_RUN]}, 32'h0);

        reset_trk();
        run_one("mul_done", 32'h7800_0000);
        chk("mul_operation", 32'(op_seen), 32'hF);
        chk("mul_t4_zin_both", 32'(op_zh), 32'h1);
        chk("mul_lo_hi", {30'b0, lo_seen, hi_seen}, 32'h3);
        chk("mul_no_rin", 32'(rin_seen), 32'h0);

        reset_trk();
        run_one("imm_done", 32'h6000_0000);
        chk("imm_cout_no_grc", {30'b0, cout_seen, grc_seen}, 32'h2);
        chk("imm_operation", 32'(op_seen), 32'hC);

        reset_trk();
        run_one("ill_done", 32'hF800_0000);
        chk("ill_one_pulse", 32'(cnt_ill), 32'd1);

        ir_s[0] = 32'hF800_0000; stop_s[0] = 1'b0; start_s[0] = 1'b1;
        cyc();
        start_s[0] = 1'b0;
        repeat (9) cyc();
        stop_s[0] = 1'b1;
        for (int i = 0; i < 20 && g_ch[0].act_v[P_RUN]; i++) cyc();

        run_one("nop_done", 32'hD000_0000);

        run_one("halt_entered", 32'hD800_0000);
        chk("halt_outs", g_ch[0].act_v, 32'h0);
        for (int i = 0; i < 10; i++) begin
            start_s[0] = ~start_s[0];
            repeat (2) cyc();
        end
        chk("halt_ignores_start", g_ch[0].act_v, 32'h0);
        clear = 1'b0;
        cyc();
        clear = 1'b1;
        cyc();

        // Asynchronous clear in T4, then stop at T5 of the following instruction
        ir_s[0] = 32'h18A1_8000; stop_s[0] = 1'b0; start_s[0] = 1'b1;
        for (int i = 0; i < 20 && g_ch[0].act_v[27:24] == 4'h0; i++) cyc();
        chk("reach_t4", 32'(g_ch[0].act_v[27:24]), 32'h3);
        #2;
        clear = 1'b0;
        #1;
        chk("clear_async_outs", g_ch[0].act_v, 32'h0);
        clear = 1'b1;
        cyc();
        for (int i = 0; i < 20 && !g_ch[0].act_v[P_GRA]; i++) cyc();
        chk("reach_t5", 32'(g_ch[0].act_v[P_GRA]), 32'h1);
        stop_s[0] = 1'b1; start_s[0] = 1'b0;
        cyc();
        chk("stop_at_t5_idle", 32'(g_ch[0].act_v[P_RUN]), 32'h0);
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 5: opcode field width, IR[31:32-OPCODE_W].
REQ-002 Parameter ALUOP_W, default 4: width of the operation output.
REQ-003 Parameter MEM_WAIT, default 0, range 0-15: extra T1 cycles the memory read is held.
REQ-004 Clock  in  1  single clock; all state changes on the rising edge.
REQ-005 clear  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  level; leaves IDLE.
REQ-007 stop  in  1  level; sampled at the end of the last step of each instruction.
REQ-008 IR  in  32  instruction register contents, valid from T3 onward.
REQ-009 PCout, Zlowout, Zhighout, MDRout, Cout  out  1 each  bus-drive selects.
REQ-010 MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high  out  1 each  register loads.
REQ-011 IncPC, Read  out  1 each  ALU increment and memory read strobe.
REQ-012 Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and general-register in/out enables.
REQ-013 operation  out  ALUOP_W  ALU function code.
REQ-014 run  out  1  high in every state except IDLE and HALT.
REQ-015 illegal  out  1  one-cycle pulse in T3 for an unsupported opcode.

Function
REQ-016 States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; one state per cycle except T1. All outputs are decoded from the registered state: asserted for the whole cycle, 0 otherwise.
REQ-017 IDLE: start=1 -> T0, else stay.
REQ-018 T0: PCout, MARin, IncPC, Zin_low.
REQ-019 T1: Zlowout, Read, MDRin for MEM_WAIT+1 cycles, counted by a wait counter; PCin only in the final T1 cycle; then T2.
REQ-020 T2: MDRout, IRin; then T3.
REQ-021 Opcode classes (opc = IR opcode field): ALU 00011-01011; IMM 01100-01110; MULDIV 01111-10000; NOP 11010; HALT 11011; all others are illegal.
REQ-022 T3: ALU/IMM/MULDIV -> Grb, Rout, Yin, then T4. NOP -> no outputs, then T0/IDLE per REQ-027. HALT -> HALT state. Illegal -> illegal=1, treated as NOP.
REQ-023 T4: operation = opc[ALUOP_W-1:0]; Zin_low=1. ALU: Grc, Rout. IMM: Cout. MULDIV: Grc, Rout, Zin_high=1. Then T5.
REQ-024 T5: ALU/IMM: Zlowout, Gra, Rin, then end of instruction. MULDIV: Zlowout, LOin, then T6.
REQ-025 T6: Zhighout, HIin, then end of instruction.
REQ-026 operation is 0 in every state other than T4.
REQ-027 End of instruction: stop=1 -> IDLE, else T0.
REQ-028 HALT: no outputs, run=0; exits only on reset. start is ignored.
REQ-029 start and stop are ignored in every state where they are not named above.
REQ-030 No two bus-drive selects (PCout, Zlowout, Zhighout, MDRout, Cout, Rout) are ever high in the same cycle.

Reset
REQ-031 clear=0 forces, without waiting for Clock: state IDLE, wait counter 0, every output 0. This applies mid-instruction and mid-T1 wait.
REQ-032 After clear rises, the first transition requires start=1 at a rising edge.

Verification
REQ-033 MEM_WAIT=0, IR=0x18A18000 (ADD, opc 00011), start=1, stop=0 -> T0,T1,T2,T3,T4,T5,T0; operation=0011 in T4 only; Gra+Rin in T5; 6 cycles per instruction.
REQ-034 MEM_WAIT=3, same ADD -> Read high for 4 consecutive cycles; PCin only in the 4th; 9 cycles per instruction.
REQ-035 IR opc=01111 (MUL) -> Zin_low+Zin_high in T4; LOin in T5; HIin in T6; Rin never asserted.
REQ-036 IR opc=01100 (IMM) -> Cout in T4, Grc low; IR opc=11111 -> illegal pulse exactly one cycle in T3, next state T0.
REQ-037 IR opc=11011 -> HALT after T3, run=0; start toggled 10 times -> state unchanged.
REQ-038 clear pulsed low during T4 (asynchronously) -> all outputs 0 immediately; stop=1 at T5 of the next instruction -> IDLE, run=0.
REQ-039 The bench checks REQ-030 every cycle in all scenarios.
